serial_alu_driver: RTL and testbench

Initiator-side companion for the bit-serial ALU.
- Queues operation commands from an upstream producer and issues them one at a time over the ALU's din valid/ready handshake.
- Captures the ALU's unstallable one-cycle result pulse and presents it downstream on a valid/ready port.
- Checks each result against an internal golden model and reports mismatches and lost results.

---
 rtl/serial_alu_pkg.sv | 37 +++
 rtl/serial_alu_cmd_fifo.sv | 45 ++++
 rtl/serial_alu_driver.sv | 179 +++++++++++++++++
 tb/tb_serial_alu_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU driver: function codes, FSM states,
// command layout and the golden result model.
package serial_alu_pkg;

   localparam logic [1:0] FUN_ADD = 2'd0;
   localparam logic [1:0] FUN_AND = 2'd1;
   localparam logic [1:0] FUN_OR  = 2'd2;
   localparam logic [1:0] FUN_XOR = 2'd3;

   localparam int unsigned CMD_W = 18;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } drv_state_t;

   typedef struct packed {
      logic [1:0] fun;
      logic [7:0] di1;
      logic [7:0] di2;
   } cmd_t;

   // Carry out of ADD is discarded; all results are mod 256.
   function automatic logic [7:0] alu_expect(input logic [7:0] di1, input logic [7:0] di2,
                                             input logic [1:0] fun);
      logic [7:0] r;
      case (fun)
         FUN_ADD: r = di1 + di2;
         FUN_AND: r = di1 & di2;
         FUN_OR:  r = di1 | di2;
         default: r = di1 ^ di2;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/serial_alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; push while full is accepted
// only when a pop happens in the same cycle.
module serial_alu_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 18
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/serial_alu_driver.sv
// Initiator for the bit-serial ALU: queues commands, issues one at a time,
// captures the result pulse and checks it against the golden model.
module serial_alu_driver
   import serial_alu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cmd_di1,
   input  logic [7:0] cmd_di2,
   input  logic [1:0] cmd_fun,
   input  logic       cmd_vld,
   output logic       cmd_rdy,
   output logic [7:0] alu_di1,
   output logic [7:0] alu_di2,
   output logic [1:0] alu_fun,
   output logic       alu_vld,
   input  logic       alu_rdy,
   input  logic [7:0] alu_dat,
   input  logic       alu_dvld,
   output logic [7:0] res_dat,
   output logic [7:0] res_exp,
   output logic       res_err,
   output logic       res_vld,
   input  logic       res_rdy,
   output logic [7:0] err_cnt,
   output logic       err_timeout
);

   localparam int unsigned    TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

   drv_state_t state_q, state_d;

   cmd_t       cmd_in, cmd_head;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic       rst_done_q;
   logic       slot_free, mismatch;

   logic [7:0]    alu_di1_q, alu_di1_d, alu_di2_q, alu_di2_d;
   logic [1:0]    alu_fun_q, alu_fun_d;
   logic          alu_vld_q, alu_vld_d;
   logic [7:0]    exp_q, exp_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    res_dat_q, res_dat_d, res_exp_q, res_exp_d;
   logic          res_err_q, res_err_d, res_vld_q, res_vld_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          err_timeout_q, err_timeout_d;

   // Holds cmd_rdy low until the first clock after reset release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rst_done_q <= 1'b0;
      else       rst_done_q <= 1'b1;
   end

   assign cmd_rdy   = rst_done_q && !fifo_full;
   assign fifo_push = cmd_vld && cmd_rdy;
   assign cmd_in    = '{fun: cmd_fun, di1: cmd_di1, di2: cmd_di2};

   serial_alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .wdata (cmd_in),
      .pop   (fifo_pop),
      .rdata (cmd_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign slot_free = !res_vld_q || res_rdy;
   assign mismatch  = (alu_dat != exp_q);

   always_comb begin
      state_d       = state_q;
      alu_di1_d     = alu_di1_q;
      alu_di2_d     = alu_di2_q;
      alu_fun_d     = alu_fun_q;
      alu_vld_d     = alu_vld_q;
      exp_d         = exp_q;
      timer_d       = timer_q;
      res_dat_d     = res_dat_q;
      res_exp_d     = res_exp_q;
      res_err_d     = res_err_q;
      res_vld_d     = res_vld_q;
      err_cnt_d     = err_cnt_q;
      err_timeout_d = err_timeout_q;
      fifo_pop      = 1'b0;

      if (res_vld_q && res_rdy) res_vld_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty && slot_free) begin
               state_d   = StIssue;
               alu_vld_d = 1'b1;
               alu_di1_d = cmd_head.di1;
               alu_di2_d = cmd_head.di2;
               alu_fun_d = cmd_head.fun;
            end
         end
         StIssue: begin
            if (alu_vld_q && alu_rdy) begin
               state_d   = StWait;
               fifo_pop  = 1'b1;
               alu_vld_d = 1'b0;
               exp_d     = alu_expect(alu_di1_q, alu_di2_q, alu_fun_q);
               timer_d   = '0;
            end
         end
         StWait: begin
            timer_d = timer_q + TIMER_ONE;
            if (alu_dvld) begin
               // Capture takes priority over a same-cycle res_rdy clear.
               state_d   = StIdle;
               res_dat_d = alu_dat;
               res_exp_d = exp_q;
               res_err_d = mismatch;
               res_vld_d = 1'b1;
               if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
            end else if (timer_q == TIMER_LAST) begin
               state_d       = StIdle;
               err_timeout_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         alu_di1_q     <= '0;
         alu_di2_q     <= '0;
         alu_fun_q     <= '0;
         alu_vld_q     <= 1'b0;
         exp_q         <= '0;
         timer_q       <= '0;
         res_dat_q     <= '0;
         res_exp_q     <= '0;
         res_err_q     <= 1'b0;
         res_vld_q     <= 1'b0;
         err_cnt_q     <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_di1_q     <= alu_di1_d;
         alu_di2_q     <= alu_di2_d;
         alu_fun_q     <= alu_fun_d;
         alu_vld_q     <= alu_vld_d;
         exp_q         <= exp_d;
         timer_q       <= timer_d;
         res_dat_q     <= res_dat_d;
         res_exp_q     <= res_exp_d;
         res_err_q     <= res_err_d;
         res_vld_q     <= res_vld_d;
         err_cnt_q     <= err_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign alu_di1     = alu_di1_q;
   assign alu_di2     = alu_di2_q;
   assign alu_fun     = alu_fun_q;
   assign alu_vld     = alu_vld_q;
   assign res_dat     = res_dat_q;
   assign res_exp     = res_exp_q;
   assign res_err     = res_err_q;
   assign res_vld     = res_vld_q;
   assign err_cnt     = err_cnt_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_serial_alu_driver.sv
// Directed bench for serial_alu_driver with a behavioural 9-cycle ALU that can be
// made to return XNOR or to drop a result pulse.
module tb_serial_alu_driver;
   import serial_alu_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cmd_di1, cmd_di2;
   logic [1:0] cmd_fun;
   logic       cmd_vld, cmd_rdy;
   logic [7:0] alu_di1, alu_di2;
   logic [1:0] alu_fun;
   logic       alu_vld, alu_rdy;
   logic [7:0] alu_dat;
   logic       alu_dvld;
   logic [7:0] res_dat, res_exp;
   logic       res_err, res_vld, res_rdy;
   logic [7:0] err_cnt;
   logic       err_timeout;

   int n_vec  = 0;
   int n_miss = 0;

   serial_alu_driver #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_di1     (cmd_di1),
      .cmd_di2     (cmd_di2),
      .cmd_fun     (cmd_fun),
      .cmd_vld     (cmd_vld),
      .cmd_rdy     (cmd_rdy),
      .alu_di1     (alu_di1),
      .alu_di2     (alu_di2),
      .alu_fun     (alu_fun),
      .alu_vld     (alu_vld),
      .alu_rdy     (alu_rdy),
      .alu_dat     (alu_dat),
      .alu_dvld    (alu_dvld),
      .res_dat     (res_dat),
      .res_exp     (res_exp),
      .res_err     (res_err),
      .res_vld     (res_vld),
      .res_rdy     (res_rdy),
      .err_cnt     (err_cnt),
      .err_timeout (err_timeout)
   );

   always #5 clock = ~clock;

   // ALU model: accept at edge T pulses alu_dvld for the cycle after edge T+8.
   int         cyc      = 0;
   int         acc_cnt  = 0;
   int         acc_cyc  = 0;
   int         drop_idx = -1;
   int         alu_mode = 0;
   logic [8:0] pipe;
   logic [7:0] pend;

   function automatic logic [7:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] f, input int mode);
      logic [7:0] r;
      case (f)
         2'd0:    r = a + b;
         2'd1:    r = a & b;
         2'd2:    r = a | b;
         default: r = (mode == 1) ? ~(a ^ b) : (a ^ b);
      endcase
      return r;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         pipe <= '0;
         pend <= '0;
      end else begin
         pipe <= {pipe[7:0], alu_vld && alu_rdy && (acc_cnt != drop_idx)};
         if (alu_vld && alu_rdy) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc + 1;
            pend    <= model_op(alu_di1, alu_di2, alu_fun, alu_mode);
         end
      end
   end

   assign alu_dvld = pipe[8];
   assign alu_dat  = pend;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge after the push edge.
   task automatic push(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      cmd_fun = f;
      cmd_di1 = a;
      cmd_di2 = b;
      cmd_vld = 1'b1;
      while (cmd_rdy !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check_eq("push.rdy", 32'(cmd_rdy), 1);
      @(negedge clock);
      cmd_vld = 1'b0;
   endtask

   task automatic wait_accept(input int start);
      int n = 0;
      while (acc_cnt == start && n < 40) begin
         @(negedge clock);
         n++;
      end
      check_eq("accept", 32'(acc_cnt - start), 1);
   endtask

   task automatic wait_result(input string tag, input logic [7:0] w_dat, input logic [7:0] w_exp,
                              input logic w_err, input logic chk_lat);
      int n = 0;
      while (res_vld !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      check_eq({tag, ".vld"}, 32'(res_vld), 1);
      check_eq({tag, ".dat"}, 32'(res_dat), 32'(w_dat));
      check_eq({tag, ".exp"}, 32'(res_exp), 32'(w_exp));
      check_eq({tag, ".err"}, 32'(res_err), 32'(w_err));
      // res_vld rises on the edge that samples alu_dvld, 9 edges after accept.
      if (chk_lat) check_eq({tag, ".lat"}, 32'(cyc - acc_cyc), 9);
      if (res_rdy) @(negedge clock);
   endtask

   initial begin
      int   a0;
      logic seen;
      cmd_vld = 1'b0;
      cmd_di1 = '0;
      cmd_di2 = '0;
      cmd_fun = '0;
      res_rdy = 1'b1;
      alu_rdy = 1'b1;

      // Reset values
      repeat (3) @(negedge clock);
      check_eq("rst.cmd_rdy", 32'(cmd_rdy), 0);
      check_eq("rst.alu_vld", 32'(alu_vld), 0);
      check_eq("rst.res_vld", 32'(res_vld), 0);
      check_eq("rst.err_cnt", 32'(err_cnt), 0);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rel.cmd_rdy", 32'(cmd_rdy), 1);

      // Back-to-back ops
      push(FUN_ADD, 8'h5A, 8'hA7);
      push(FUN_AND, 8'hF0, 8'h3C);
      wait_result("b2b0", 8'h01, 8'h01, 1'b0, 1'b1);
      wait_result("b2b1", 8'h30, 8'h30, 1'b0, 1'b1);

      // ALU returns XNOR for XOR
      alu_mode = 1;
      push(FUN_XOR, 8'hF0, 8'h3C);
      wait_result("xnor", 8'h33, 8'hCC, 1'b1, 1'b1);
      check_eq("xnor.err_cnt", 32'(err_cnt), 1);
      alu_mode = 0;

      // Result backpressure
      res_rdy = 1'b0;
      push(FUN_OR, 8'h81, 8'h18);
      push(FUN_ADD, 8'hFF, 8'h01);
      wait_result("bp0", 8'h99, 8'h99, 1'b0, 1'b1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (alu_vld) seen = 1'b1;
      end
      check_eq("bp.hold_vld", 32'(res_vld), 1);
      check_eq("bp.hold_dat", 32'(res_dat), 32'h99);
      check_eq("bp.no_issue", 32'(seen), 0);
      res_rdy = 1'b1;
      @(negedge clock);
      res_rdy = 1'b0;
      check_eq("bp.cleared", 32'(res_vld), 0);
      wait_result("bp1", 8'h00, 8'h00, 1'b0, 1'b1);
      res_rdy = 1'b1;
      @(negedge clock);

      // FIFO full with ALU stalled
      alu_rdy = 1'b0;
      push(FUN_ADD, 8'h01, 8'h02);
      push(FUN_AND, 8'hFF, 8'h0F);
      push(FUN_OR,  8'h10, 8'h01);
      push(FUN_XOR, 8'hAA, 8'h55);
      check_eq("full.cmd_rdy", 32'(cmd_rdy), 0);
      check_eq("full.alu_vld", 32'(alu_vld), 1);
      repeat (5) @(negedge clock);
      check_eq("full.di1", 32'(alu_di1), 32'h01);
      check_eq("full.di2", 32'(alu_di2), 32'h02);
      check_eq("full.fun", 32'(alu_fun), 0);
      check_eq("full.vld_hold", 32'(alu_vld), 1);
      alu_rdy = 1'b1;
      push(FUN_ADD, 8'h80, 8'h80);
      wait_result("q0", 8'h03, 8'h03, 1'b0, 1'b0);
      wait_result("q1", 8'h0F, 8'h0F, 1'b0, 1'b0);
      wait_result("q2", 8'h11, 8'h11, 1'b0, 1'b0);
      wait_result("q3", 8'hFF, 8'hFF, 1'b0, 1'b0);
      wait_result("q4", 8'h00, 8'h00, 1'b0, 1'b0);

      // Timeout: first accepted op never pulses
      a0       = acc_cnt;
      drop_idx = a0;
      push(FUN_ADD, 8'h11, 8'h22);
      push(FUN_ADD, 8'h02, 8'h02);
      wait_accept(a0);
      repeat (15) @(negedge clock);
      check_eq("to.not_yet", 32'(err_timeout), 0);
      @(negedge clock);
      check_eq("to.flag", 32'(err_timeout), 1);
      check_eq("to.no_res", 32'(res_vld), 0);
      wait_result("to.next", 8'h04, 8'h04, 1'b0, 1'b1);
      check_eq("to.sticky", 32'(err_timeout), 1);

      // Reset during WAIT with an op still queued
      a0 = acc_cnt;
      push(FUN_ADD, 8'h33, 8'h44);
      push(FUN_OR,  8'h0F, 8'hF0);
      wait_accept(a0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      check_eq("mid.err_cnt", 32'(err_cnt), 0);
      check_eq("mid.err_to", 32'(err_timeout), 0);
      check_eq("mid.di1", 32'(alu_di1), 0);
      check_eq("mid.cmd_rdy", 32'(cmd_rdy), 0);
      check_eq("mid.res_vld", 32'(res_vld), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("mid.rel_rdy", 32'(cmd_rdy), 1);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clock);
         if (alu_vld || res_vld) seen = 1'b1;
      end
      check_eq("mid.fifo_empty", 32'(seen), 0);
      push(FUN_ADD, 8'h02, 8'h03);
      wait_result("mid.fresh", 8'h05, 8'h05, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
